// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO link manager: register map, bit positions,
// FSM states and the MDIO_ADDR/MDIO_CTRL word builders.
package mdio_pkg;

  localparam logic [11:0] MDIO_ADDR_OFS = 12'h7E4;
  localparam logic [11:0] MDIO_WR_OFS   = 12'h7E8;
  localparam logic [11:0] MDIO_RD_OFS   = 12'h7EC;
  localparam logic [11:0] MDIO_CTRL_OFS = 12'h7F0;

  localparam int CTRL_BUSY_BIT = 0;
  localparam int CTRL_EN_BIT   = 3;
  localparam int OP_READ_BIT   = 10;
  localparam int BMSR_LINK_BIT = 2;
  localparam int BMSR_ANC_BIT  = 5;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    WR_ADDR,
    WR_CTRL,
    RD_CTRL,
    RD_DATA,
    DONE
  } state_t;

  function automatic logic [31:0] addr_word(input logic [4:0] phy, input logic [4:0] rg);
    logic [31:0] w;
    w              = '0;
    w[OP_READ_BIT] = 1'b1;
    w[9:5]         = phy;
    w[4:0]         = rg;
    return w;
  endfunction

  function automatic logic [31:0] ctrl_start_word();
    logic [31:0] w;
    w                = '0;
    w[CTRL_EN_BIT]   = 1'b1;
    w[CTRL_BUSY_BIT] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/mdio_link_mgr_if.sv
// Register-access request/done bus between the link manager and the MDIO
// controller register block.
interface mdio_link_mgr_if #(
  parameter int P_AXI_ADDR_WIDTH = 13,
  parameter int P_AXI_DATA_WIDTH = 32
);
  logic                        do_axi_write;
  logic [P_AXI_ADDR_WIDTH-1:0] axi_write_addr;
  logic [P_AXI_DATA_WIDTH-1:0] axi_write_data;
  logic                        write_done;
  logic                        do_axi_read;
  logic [P_AXI_ADDR_WIDTH-1:0] axi_read_addr;
  logic [P_AXI_DATA_WIDTH-1:0] axi_read_data;
  logic                        read_done;

  modport master (
    output do_axi_write, axi_write_addr, axi_write_data,
    input  write_done,
    output do_axi_read, axi_read_addr,
    input  axi_read_data, read_done
  );

  modport slave (
    input  do_axi_write, axi_write_addr, axi_write_data,
    output write_done,
    input  do_axi_read, axi_read_addr,
    output axi_read_data, read_done
  );
endinterface

// File: rtl/mdio_link_mgr_poll_timer.sv
// Poll interval counter: counts while enabled, wraps at P_CYCLES-1 with a
// one-cycle expiry pulse; clear has priority over counting.
module poll_timer #(
  parameter int P_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);
  localparam int CW = ($clog2(P_CYCLES) > 0) ? $clog2(P_CYCLES) : 1;

  logic [CW-1:0] cnt_reg;
  logic          at_end;

  assign at_end = (cnt_reg == CW'(P_CYCLES - 1));
  assign expire = en && at_end && !clr;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= at_end ? '0 : cnt_reg + 1'b1;
    end
  end
endmodule

// File: rtl/mdio_link_mgr.sv
// Periodically polls PHY BMSR (reg 1) through the MDIO controller register
// block and serves user register reads, one register access at a time.
module mdio_link_mgr
  import mdio_pkg::*;
#(
  parameter int         P_AXI_ADDR_WIDTH = 13,
  parameter int         P_AXI_DATA_WIDTH = 32,
  parameter logic [4:0] P_PHY_ADDR       = 5'd0,
  parameter int         P_POLL_CYCLES    = 1_000_000,
  parameter int         P_BUSY_TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  mdio_link_mgr_if.master        bus,
  input  logic                   poll_en,
  input  logic                   usr_req,
  input  logic [4:0]             usr_reg,
  output logic                   usr_ack,
  output logic [15:0]            usr_data,
  output logic [15:0]            phy_status,
  output logic                   link_up,
  output logic                   an_complete,
  output logic                   status_valid,
  output logic                   timeout_err
);
  localparam int AW = P_AXI_ADDR_WIDTH;
  localparam int DW = P_AXI_DATA_WIDTH;
  localparam int BW = $clog2(P_BUSY_TIMEOUT + 1);

  state_t        state_reg, state_next;
  logic          pend_reg, pend_next;
  logic          src_user_reg, src_user_next;
  logic [4:0]    reg_sel_reg, reg_sel_next;
  logic [BW-1:0] busy_cnt_reg, busy_cnt_next;
  logic          tmo_cur_reg, tmo_cur_next;
  logic          poll_due_reg, poll_due_next;
  logic [15:0]   phy_status_reg, phy_status_next;
  logic [15:0]   usr_data_reg, usr_data_next;
  logic          timeout_err_reg, timeout_err_next;

  logic          tmr_en, tmr_clr, tmr_expire;
  logic          wr_pulse, rd_pulse;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          unused_rd_bits;

  poll_timer #(.P_CYCLES(P_POLL_CYCLES)) u_poll_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (tmr_en),
    .clr    (tmr_clr),
    .expire (tmr_expire)
  );

  // The interval only runs while idle with nothing pending, so a deferred
  // poll never stacks up a second expiry.
  assign tmr_en = (state_reg == IDLE) && poll_en && !poll_due_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      pend_reg        <= 1'b0;
      src_user_reg    <= 1'b0;
      reg_sel_reg     <= '0;
      busy_cnt_reg    <= '0;
      tmo_cur_reg     <= 1'b0;
      poll_due_reg    <= 1'b0;
      phy_status_reg  <= '0;
      usr_data_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pend_reg        <= pend_next;
      src_user_reg    <= src_user_next;
      reg_sel_reg     <= reg_sel_next;
      busy_cnt_reg    <= busy_cnt_next;
      tmo_cur_reg     <= tmo_cur_next;
      poll_due_reg    <= poll_due_next;
      phy_status_reg  <= phy_status_next;
      usr_data_reg    <= usr_data_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  // Each access state issues its pulse while nothing is outstanding, then
  // waits; done pulses are only honoured while the matching access is pending.
  always_comb begin
    state_next       = state_reg;
    pend_next        = pend_reg;
    src_user_next    = src_user_reg;
    reg_sel_next     = reg_sel_reg;
    busy_cnt_next    = busy_cnt_reg;
    tmo_cur_next     = tmo_cur_reg;
    poll_due_next    = poll_en && (poll_due_reg || tmr_expire);
    phy_status_next  = phy_status_reg;
    usr_data_next    = usr_data_reg;
    timeout_err_next = timeout_err_reg;
    tmr_clr          = !poll_en;
    wr_pulse         = 1'b0;
    rd_pulse         = 1'b0;
    wr_addr          = '0;
    wr_data          = '0;
    rd_addr          = '0;
    usr_ack          = 1'b0;
    status_valid     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (usr_req || poll_due_reg) state_next = ARB;
      end
      ARB: begin
        busy_cnt_next = '0;
        tmo_cur_next  = 1'b0;
        if (usr_req) begin
          src_user_next = 1'b1;
          reg_sel_next  = usr_reg;
          state_next    = WR_ADDR;
        end else if (poll_due_reg) begin
          src_user_next = 1'b0;
          reg_sel_next  = 5'd1;
          state_next    = WR_ADDR;
        end else begin
          state_next = IDLE;
        end
      end
      WR_ADDR: begin
        wr_addr  = AW'(MDIO_ADDR_OFS);
        wr_data  = DW'(addr_word(P_PHY_ADDR, reg_sel_reg));
        wr_pulse = !pend_reg;
        if (pend_reg && bus.write_done) begin
          pend_next  = 1'b0;
          state_next = WR_CTRL;
        end
      end
      WR_CTRL: begin
        wr_addr  = AW'(MDIO_CTRL_OFS);
        wr_data  = DW'(ctrl_start_word());
        wr_pulse = !pend_reg;
        if (pend_reg && bus.write_done) begin
          pend_next  = 1'b0;
          state_next = RD_CTRL;
        end
      end
      RD_CTRL: begin
        rd_addr  = AW'(MDIO_CTRL_OFS);
        rd_pulse = !pend_reg;
        if (pend_reg && bus.read_done) begin
          pend_next = 1'b0;
          if (!bus.axi_read_data[CTRL_BUSY_BIT]) begin
            state_next = RD_DATA;
          end else if (busy_cnt_reg == BW'(P_BUSY_TIMEOUT - 1)) begin
            timeout_err_next = 1'b1;
            tmo_cur_next     = 1'b1;
            if (src_user_reg) usr_data_next = 16'hFFFF;
            state_next = DONE;
          end else begin
            busy_cnt_next = busy_cnt_reg + 1'b1;
          end
        end
      end
      RD_DATA: begin
        rd_addr  = AW'(MDIO_RD_OFS);
        rd_pulse = !pend_reg;
        if (pend_reg && bus.read_done) begin
          pend_next = 1'b0;
          if (src_user_reg) usr_data_next = bus.axi_read_data[15:0];
          else              phy_status_next = bus.axi_read_data[15:0];
          state_next = DONE;
        end
      end
      DONE: begin
        if (src_user_reg) begin
          usr_ack = 1'b1;
        end else begin
          status_valid  = !tmo_cur_reg;
          poll_due_next = 1'b0;
          tmr_clr       = 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (wr_pulse || rd_pulse) pend_next = 1'b1;
  end

  assign bus.do_axi_write   = wr_pulse;
  assign bus.axi_write_addr = wr_addr;
  assign bus.axi_write_data = wr_data;
  assign bus.do_axi_read    = rd_pulse;
  assign bus.axi_read_addr  = rd_addr;
  assign unused_rd_bits     = ^bus.axi_read_data[DW-1:16];

  assign usr_data    = usr_data_reg;
  assign phy_status  = phy_status_reg;
  assign link_up     = phy_status_reg[BMSR_LINK_BIT];
  assign an_complete = phy_status_reg[BMSR_ANC_BIT];
  assign timeout_err = timeout_err_reg;
endmodule

// File: tb/tb_mdio_link_mgr.sv
// Self-checking bench for mdio_link_mgr: register-block model with an
// expected-access scoreboard, table-driven polls and hand-written corner cases.
module tb_mdio_link_mgr;
  localparam int AW = 13;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        poll_en = 1'b0;
  logic        usr_req = 1'b0;
  logic [4:0]  usr_reg = 5'd0;
  logic        usr_ack;
  logic [15:0] usr_data;
  logic [15:0] phy_status;
  logic        link_up, an_complete, status_valid, timeout_err;

  always #5 clk = ~clk;

  mdio_link_mgr_if #(.P_AXI_ADDR_WIDTH(AW), .P_AXI_DATA_WIDTH(DW)) bus ();

  mdio_link_mgr #(
    .P_AXI_ADDR_WIDTH (AW),
    .P_AXI_DATA_WIDTH (DW),
    .P_PHY_ADDR       (5'd0),
    .P_POLL_CYCLES    (100),
    .P_BUSY_TIMEOUT   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .poll_en      (poll_en),
    .usr_req      (usr_req),
    .usr_reg      (usr_reg),
    .usr_ack      (usr_ack),
    .usr_data     (usr_data),
    .phy_status   (phy_status),
    .link_up      (link_up),
    .an_complete  (an_complete),
    .status_valid (status_valid),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    logic [31:0] rd_value;
    int          busy;
    logic [15:0] exp_status;
    bit          exp_link;
    bit          exp_anc;
  } vec_t;

  acc_t        exp_q[$];
  int          exp_rd = 0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] rd_value = 32'h0;
  int          busy_cfg = 0;
  bit          busy_stuck = 1'b0;
  int          inject_req = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_acc(input bit w, input logic [31:0] a, input logic [31:0] d);
    acc_t e;
    e.is_wr = w;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic push_txn(input logic [4:0] rg, input int ctrl_reads, input bit with_data);
    push_acc(1'b1, 32'h7E4, 32'h400 | {27'd0, rg});
    push_acc(1'b1, 32'h7F0, 32'h9);
    for (int k = 0; k < ctrl_reads; k++) push_acc(1'b0, 32'h7F0, 32'h0);
    if (with_data) push_acc(1'b0, 32'h7EC, 32'h0);
  endtask

  // which: 0 status_valid, 1 usr_ack, 2 timeout_err, 3 write pulse, 4 MDIO_CTRL read pulse
  task automatic wait_for(input int which, input int budget, input string name);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      tick(1);
      n++;
      case (which)
        0:       hit = status_valid;
        1:       hit = usr_ack;
        2:       hit = timeout_err;
        3:       hit = bus.do_axi_write;
        default: hit = bus.do_axi_read && (bus.axi_read_addr == 13'h7F0);
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: event not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(exp_rd), 32'(exp_q.size()));
  endtask

  // Register-block model: one-cycle-late sampling, fixed 2-cycle access latency,
  // checks every pulse against the scoreboard and the bus rules while pending.
  initial begin
    bit          pend;
    bit          cap_wr;
    bit          busy;
    logic [31:0] cap_addr, cap_data;
    int          lat;
    int          ctrl_reads;
    int          inject_seen;
    acc_t        e;
    pend = 1'b0; cap_wr = 1'b0; cap_addr = '0; cap_data = '0;
    lat = 0; ctrl_reads = 0; inject_seen = 0;
    bus.write_done    = 1'b0;
    bus.read_done     = 1'b0;
    bus.axi_read_data = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.write_done = 1'b0;
      bus.read_done  = 1'b0;
      if (!rst) begin
        pend       = 1'b0;
        exp_rd     = exp_q.size();
        ctrl_reads = 0;
      end else begin
        if (inject_seen != inject_req) begin
          inject_seen       = inject_req;
          bus.read_done     = 1'b1;
          bus.axi_read_data = 32'h0000_FFFF;
          $display("bus: stray read_done injected");
        end
        if (pend) begin
          check("one_outstanding", {30'd0, bus.do_axi_write, bus.do_axi_read}, 32'h0);
          if (cap_wr) begin
            check("wr_addr_stable", 32'(bus.axi_write_addr), cap_addr);
            check("wr_data_stable", bus.axi_write_data, cap_data);
          end else begin
            check("rd_addr_stable", 32'(bus.axi_read_addr), cap_addr);
          end
          lat--;
          if (lat == 0) begin
            pend = 1'b0;
            if (cap_wr) begin
              bus.write_done = 1'b1;
            end else begin
              bus.read_done = 1'b1;
              if (cap_addr == 32'h7F0) begin
                busy = busy_stuck || (ctrl_reads < busy_cfg);
                ctrl_reads++;
                bus.axi_read_data = {31'd0, busy};
              end else if (cap_addr == 32'h7EC) begin
                bus.axi_read_data = rd_value;
              end else begin
                bus.axi_read_data = 32'hDEAD_0000;
              end
            end
          end
        end else if (bus.do_axi_write || bus.do_axi_read) begin
          check("no_rd_wr_together", {31'd0, bus.do_axi_write && bus.do_axi_read}, 32'h0);
          cap_wr   = bus.do_axi_write;
          cap_addr = cap_wr ? 32'(bus.axi_write_addr) : 32'(bus.axi_read_addr);
          cap_data = bus.axi_write_data;
          if (cap_wr) $display("bus: write addr 0x%0h data 0x%0h", cap_addr, cap_data);
          else        $display("bus: read  addr 0x%0h", cap_addr);
          if (exp_rd >= exp_q.size()) begin
            checks++;
            errors++;
            $display("FAIL unexpected_access: got addr 0x%0h wr %0d, expected none", cap_addr, cap_wr);
          end else begin
            e = exp_q[exp_rd];
            exp_rd++;
            check("acc_type", {31'd0, cap_wr}, {31'd0, e.is_wr});
            check("acc_addr", cap_addr, e.addr);
            if (e.is_wr) check("acc_data", cap_data, e.data);
          end
          if (cap_wr && cap_addr == 32'h7E4) ctrl_reads = 0;
          pend = 1'b1;
          lat  = 2;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   sv_cnt, pulse_cnt;
    vecs[0] = '{32'h0000_786D, 1, 16'h786D, 1'b1, 1'b1};
    vecs[1] = '{32'h0000_7849, 0, 16'h7849, 1'b0, 1'b0};
    vecs[2] = '{32'hABCD_0004, 2, 16'h0004, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0020, 0, 16'h0020, 1'b0, 1'b1};

    // Reset values
    tick(3);
    check("rst_do_write", {31'd0, bus.do_axi_write}, 32'h0);
    check("rst_do_read", {31'd0, bus.do_axi_read}, 32'h0);
    check("rst_write_addr", 32'(bus.axi_write_addr), 32'h0);
    check("rst_write_data", bus.axi_write_data, 32'h0);
    check("rst_read_addr", 32'(bus.axi_read_addr), 32'h0);
    check("rst_phy_status", 32'(phy_status), 32'h0);
    check("rst_flags", {27'd0, link_up, an_complete, timeout_err, usr_ack, status_valid}, 32'h0);
    check("rst_usr_data", 32'(usr_data), 32'h0);
    rst = 1'b1;

    tick(150);
    check_drained("no_poll_while_disabled");

    // Table-driven polls
    for (int i = 0; i < 4; i++) begin
      rd_value = vecs[i].rd_value;
      busy_cfg = vecs[i].busy;
      push_txn(5'd1, vecs[i].busy + 1, 1'b1);
      poll_en = 1'b1;
      wait_for(0, 400, "poll_status_valid");
      $display("poll %0d: phy_status 0x%0h link %0d anc %0d", i, phy_status, link_up, an_complete);
      check("poll_phy_status", 32'(phy_status), 32'(vecs[i].exp_status));
      check("poll_link_up", {31'd0, link_up}, {31'd0, vecs[i].exp_link});
      check("poll_an_complete", {31'd0, an_complete}, {31'd0, vecs[i].exp_anc});
      check_drained("poll_accesses");
    end

    // User request arriving in the same cycle poll_due is set: user goes first
    usr_reg  = 5'd2;
    rd_value = 32'h1234_BEEF;
    busy_cfg = 0;
    push_txn(5'd2, 1, 1'b1);
    push_txn(5'd1, 1, 1'b1);
    tick(101);
    usr_req = 1'b1;
    wait_for(1, 200, "usr_ack_priority");
    usr_req  = 1'b0;
    rd_value = 32'h0000_782C;
    $display("user reg 2: usr_data 0x%0h", usr_data);
    check("usr_data_priority", 32'(usr_data), 32'h0000_BEEF);
    tick(1);
    check("usr_ack_one_cycle", {31'd0, usr_ack}, 32'h0);
    wait_for(0, 200, "poll_after_user");
    check("poll_after_user_status", 32'(phy_status), 32'h0000_782C);
    check_drained("priority_accesses");

    // Busy stuck on a poll: exactly 8 MDIO_CTRL reads then timeout
    busy_stuck = 1'b1;
    push_txn(5'd1, 8, 1'b0);
    wait_for(2, 300, "poll_timeout_err");
    poll_en = 1'b0;
    sv_cnt  = 0;
    for (int k = 0; k < 20; k++) begin
      if (status_valid) sv_cnt++;
      tick(1);
    end
    $display("poll timeout: timeout_err %0d phy_status 0x%0h", timeout_err, phy_status);
    check("timeout_no_status_valid", 32'(sv_cnt), 32'h0);
    check("timeout_status_kept", 32'(phy_status), 32'h0000_782C);
    check_drained("timeout_accesses");

    // Busy stuck on a user read: ack carries 0xFFFF
    usr_reg = 5'd3;
    push_txn(5'd3, 8, 1'b0);
    usr_req = 1'b1;
    wait_for(1, 200, "usr_ack_timeout");
    usr_req = 1'b0;
    $display("user reg 3 timeout: usr_data 0x%0h", usr_data);
    check("usr_data_timeout", 32'(usr_data), 32'h0000_FFFF);
    check("timeout_err_sticky", {31'd0, timeout_err}, 32'h1);
    busy_stuck = 1'b0;
    tick(5);
    check_drained("usr_timeout_accesses");

    // usr_req dropped before ack still completes with an ack
    usr_reg  = 5'd4;
    rd_value = 32'h0000_A5A5;
    push_txn(5'd4, 1, 1'b1);
    usr_req = 1'b1;
    tick(3);
    usr_req = 1'b0;
    wait_for(1, 200, "usr_ack_after_drop");
    $display("user reg 4 dropped: usr_data 0x%0h", usr_data);
    check("usr_data_after_drop", 32'(usr_data), 32'h0000_A5A5);
    tick(30);
    check_drained("drop_accesses");

    // usr_req held across an ack starts a second transaction
    usr_reg  = 5'd5;
    rd_value = 32'h0000_5A5A;
    push_txn(5'd5, 1, 1'b1);
    push_txn(5'd5, 1, 1'b1);
    usr_req = 1'b1;
    wait_for(1, 200, "usr_ack_first");
    check("usr_data_first", 32'(usr_data), 32'h0000_5A5A);
    wait_for(1, 200, "usr_ack_second");
    usr_req = 1'b0;
    $display("user reg 5 held: two acks, usr_data 0x%0h", usr_data);
    tick(30);
    check_drained("held_accesses");

    // poll_en dropped mid-poll: poll finishes, no further polls
    rd_value = 32'h0000_0004;
    push_txn(5'd1, 1, 1'b1);
    poll_en = 1'b1;
    wait_for(3, 300, "poll_started");
    poll_en = 1'b0;
    wait_for(0, 100, "status_after_poll_en_drop");
    check("drop_poll_status", 32'(phy_status), 32'h0000_0004);
    check("drop_poll_flags", {30'd0, link_up, an_complete}, 32'h2);
    tick(250);
    check_drained("no_poll_after_disable");

    // Reset while waiting on MDIO_CTRL, then a stray read_done
    busy_stuck = 1'b1;
    push_txn(5'd1, 8, 1'b0);
    poll_en = 1'b1;
    wait_for(4, 300, "rd_ctrl_reached");
    tick(1);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    busy_stuck = 1'b0;
    inject_req++;
    tick(2);
    check("rst2_phy_status", 32'(phy_status), 32'h0);
    check("rst2_flags", {27'd0, link_up, an_complete, timeout_err, usr_ack, status_valid}, 32'h0);
    check("rst2_usr_data", 32'(usr_data), 32'h0);
    check("rst2_addrs", 32'(bus.axi_write_addr) | 32'(bus.axi_read_addr) | bus.axi_write_data, 32'h0);
    pulse_cnt = 0;
    for (int k = 0; k < 88; k++) begin
      if (bus.do_axi_write || bus.do_axi_read) pulse_cnt++;
      tick(1);
    end
    $display("after reset: %0d request pulses before next poll", pulse_cnt);
    check("rst2_no_pulses", 32'(pulse_cnt), 32'h0);
    rd_value = 32'h0000_0024;
    push_txn(5'd1, 1, 1'b1);
    wait_for(0, 200, "poll_after_reset");
    check("poll_after_reset_status", 32'(phy_status), 32'h0000_0024);
    check_drained("reset_accesses");
    poll_en = 1'b0;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdio_link_mgr.md
MDIO_LINK_MGR -- requirements
Module: mdio_link_mgr

Interface
REQ-001 Parameters (name, default, meaning): P_AXI_ADDR_WIDTH, 13, AXI address width; P_AXI_DATA_WIDTH, 32, AXI data width; P_PHY_ADDR, 5'd0, PHY address; P_POLL_CYCLES, 1_000_000, clk cycles between status polls; P_BUSY_TIMEOUT, 1024, max MDIO_CTRL busy reads per transaction.
REQ-002 Ports (name, direction, width, meaning): clk, in, 1, clock; rst, in, 1, synchronous active-low reset.
REQ-003 do_axi_write, out, 1, write request pulse; axi_write_addr, out, P_AXI_ADDR_WIDTH, write address; axi_write_data, out, P_AXI_DATA_WIDTH, write data; write_done, in, 1, write complete pulse.
REQ-004 do_axi_read, out, 1, read request pulse; axi_read_addr, out, P_AXI_ADDR_WIDTH, read address; axi_read_data, in, P_AXI_DATA_WIDTH, read data, valid with read_done; read_done, in, 1, read complete pulse.
REQ-005 poll_en, in, 1, enable periodic polling of PHY reg 1; usr_req, in, 1, user MDIO read request (level, held until usr_ack); usr_reg, in, 5, user register address; usr_ack, out, 1, one-cycle completion pulse; usr_data, out, 16, user read result.
REQ-006 phy_status, out, 16, last PHY reg 1 value; link_up, out, 1, phy_status[2]; an_complete, out, 1, phy_status[5]; status_valid, out, 1, one-cycle pulse on phy_status update; timeout_err, out, 1, sticky busy-timeout flag.

Function
REQ-007 Registers: MDIO_ADDR 0x7E4, MDIO_WR 0x7E8, MDIO_RD 0x7EC, MDIO_CTRL 0x7F0; MDIO_ADDR word = {21'b0, op bit10 = 1 (read), phy[9:5], reg[4:0]}; PHY 0, reg 1 gives 0x00000401.
REQ-008 FSM states: IDLE, ARB, WR_ADDR, WR_CTRL, RD_CTRL, RD_DATA, DONE.
REQ-009 IDLE: poll timer counts up to P_POLL_CYCLES-1 while poll_en=1 and holds at zero while poll_en=0; timer expiry sets poll_due; go to ARB when poll_due or usr_req.
REQ-010 ARB: usr_req takes priority over poll_due; latch the selected reg (usr_reg or 5'd1) and source flag; poll_due stays set when deferred.
REQ-011 WR_ADDR: write MDIO_ADDR word; WR_CTRL: write 0x00000009 (enable bit3, busy bit0) to MDIO_CTRL.
REQ-012 RD_CTRL: read MDIO_CTRL; bit0=1 reissues the read (count+1); bit0=0 goes to RD_DATA; count reaching P_BUSY_TIMEOUT sets timeout_err and goes to DONE with no result update; user ack then carries usr_data=16'hFFFF.
REQ-013 RD_DATA: read MDIO_RD; take axi_read_data[15:0] as the result.
REQ-014 DONE (1 cycle): poll source updates phy_status/link_up/an_complete, pulses status_valid and clears poll_due and the timer; user source drives usr_data and pulses usr_ack; return to IDLE.
REQ-015 Handshake: do_axi_write/do_axi_read high exactly one cycle per access; address/data stable from the pulse until the done pulse; never more than one outstanding access; no read and write together.
REQ-016 Next request issues no earlier than 1 cycle after the previous done.
REQ-017 A done pulse with no access outstanding is ignored.
REQ-018 poll_en deasserted mid-transaction: the transaction completes and updates status; no new poll starts.
REQ-019 usr_req dropped before ack: the transaction completes and still pulses usr_ack.
REQ-020 usr_req held after usr_ack: treated as a new request.

Reset
REQ-021 rst=0 at clk edge: state IDLE; timer, busy count, poll_due = 0; all request pulses, usr_ack, status_valid = 0; addresses/data 0; phy_status 0x0000; link_up, an_complete, timeout_err = 0; usr_data 0.
REQ-022 Reset mid-transaction abandons the access immediately; a late done pulse after reset is ignored.

Structure
REQ-023 Shared package mdio_pkg holds register offsets, the MDIO_CTRL bit positions (busy 0, enable 3), the op-read bit (10), the BMSR bit positions (link 2, autoneg-complete 5) and the FSM state enum.
REQ-024 The poll interval counter is sub-module poll_timer (enable, clear, expiry pulse); the rest is flat.

Verification
REQ-025 poll_en=1, P_POLL_CYCLES=100, model returns busy once then 0, MDIO_RD=0x0000786D -> writes 0x401@0x7E4, 0x9@0x7F0; two 0x7F0 reads; link_up=1, an_complete=1, status_valid pulse.
REQ-026 MDIO_RD=0x00007849 -> phy_status=0x7849, link_up=0, an_complete=0.
REQ-027 usr_req with usr_reg=2 and poll_due in the same cycle -> user first (MDIO_ADDR=0x402), usr_data=MDIO_RD[15:0], usr_ack; poll (0x401) follows.
REQ-028 Busy stuck at 1, P_BUSY_TIMEOUT=8 -> exactly 8 MDIO_CTRL reads, timeout_err=1, phy_status unchanged, FSM back in IDLE.
REQ-029 rst pulsed during RD_CTRL, late read_done injected -> all outputs at reset values, no request pulses until the next poll.
REQ-030 Bench checker (all scenarios): at most one outstanding access; address/data stable until done.
